// File: rtl/mem_pkg.sv
// Definitions shared by the wait-state memory model and the CPU memory port:
// FSM encoding and the default bus geometry.
package mem_pkg;

    localparam int              DEF_DATA_W    = 16;
    localparam int              DEF_ADDR_W    = 16;
    localparam int              DEF_DEPTH     = 1024;
    localparam logic [15:0]     DEF_INIT_WORD = 16'hC000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Word-wide RAM with synchronous write and registered read, kept apart from
// the control FSM so that synthesis maps it onto block RAM.
module mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    // Write-first: a read issued on the same edge as a write to the same word
    // sees the new data, which back-to-back write/read at zero wait needs.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data_reg <= (we && (wr_addr == rd_addr)) ? wr_data : mem_reg[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/mem_wait_model.sv
// Memory slave for the stack CPU: request/ready handshake with a programmable
// number of wait states, back-to-back acceptance and an out-of-range response.
module mem_wait_model
    import mem_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DEPTH     = DEF_DEPTH,
    parameter int                WAIT      = 2,
    parameter logic [DATA_W-1:0] INIT_WORD = DEF_INIT_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              error
);

    localparam int              IDX_W   = $clog2(DEPTH);
    localparam logic [3:0]      WAIT_L  = 4'(WAIT);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    mem_state_t        state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;

    logic              accept;
    logic              out_of_range;
    logic              mem_we;
    logic              mem_re;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] mem_q;

    assign out_of_range = ({1'b0, addr_reg} >= DEPTH_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        accept     = 1'b0;
        case (state_reg)
            // DONE accepts exactly like IDLE so continuous req streams accesses.
            ST_IDLE, ST_DONE: begin
                if (req) begin
                    accept     = 1'b1;
                    we_next    = we;
                    addr_next  = addr;
                    wdata_next = wdata;
                    cnt_next   = WAIT_L;
                    state_next = (WAIT_L != 4'd0) ? ST_WAIT : ST_DONE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg <= 4'd1) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The read is launched on the edge that enters DONE; with zero wait that
    // edge is also the acceptance edge, so the address comes straight from addr.
    assign rd_idx = accept ? addr[IDX_W-1:0] : addr_reg[IDX_W-1:0];
    assign mem_re = (state_next == ST_DONE);
    assign mem_we = (state_reg == ST_DONE) && we_reg && !out_of_range;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem_array (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (addr_reg[IDX_W-1:0]),
        .wr_data (wdata_reg),
        .re      (mem_re),
        .rd_addr (rd_idx),
        .rd_data (mem_q)
    );

    assign ready = (state_reg == ST_DONE);
    assign busy  = (state_reg != ST_IDLE);
    assign error = ready && out_of_range;

    always_comb begin
        rdata = '0;
        if (ready) begin
            if (out_of_range) begin
                rdata = INIT_WORD;
            end else if (!we_reg) begin
                rdata = mem_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_wait_model.sv
// Directed bench for mem_wait_model: one instance per wait-state setting,
// driven by a single linear stimulus sequence with hand-computed expectations.
module tb_mem_wait_model;

    localparam int NI = 5;
    localparam int WAITS [NI] = '{2, 0, 1, 5, 15};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        req_v   [NI];
    logic [15:0] rdata_v [NI];
    logic        ready_v [NI];
    logic        busy_v  [NI];
    logic        error_v [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        mem_wait_model #(
            .DATA_W    (16),
            .ADDR_W    (16),
            .DEPTH     (1024),
            .WAIT      (WAITS[gi]),
            .INIT_WORD (16'hC000)
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .req   (req_v[gi]),
            .we    (we),
            .addr  (addr),
            .wdata (wdata),
            .rdata (rdata_v[gi]),
            .ready (ready_v[gi]),
            .busy  (busy_v[gi]),
            .error (error_v[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access on instance i; lat/bz are counted in samples taken
    // 1 time unit after each edge, starting with the acceptance edge.
    task automatic access(input int i, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input bit churn,
                          output logic [15:0] rd, output logic er,
                          output int lat, output int bz);
        req_v[i] = 1'b1;
        we       = w;
        addr     = a;
        wdata    = d;
        tick();
        req_v[i] = 1'b0;
        lat = 0;
        bz  = 0;
        rd  = '0;
        er  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (!busy_v[i]) break;
            bz++;
            if (ready_v[i]) begin
                lat = k;
                rd  = rdata_v[i];
                er  = error_v[i];
            end
            if (churn) begin
                we    = ~w;
                addr  = 16'($urandom_range(0, 1023));
                wdata = 16'($urandom);
            end
            tick();
        end
    endtask

    logic [15:0] rd;
    logic        er;
    int          lat, bz;

    initial begin
        for (int i = 0; i < NI; i++) req_v[i] = 1'b0;

        // Reset state
        tick();
        tick();
        check("reset_outputs", 32'({rdata_v[0], ready_v[0], busy_v[0], error_v[0]}), 32'h0);
        rst = 1'b0;
        tick();

        // Baseline value at addr 5, then abort a write mid-WAIT
        access(0, 1'b1, 16'd5, 16'h1111, 1'b0, rd, er, lat, bz);
        req_v[0] = 1'b1; we = 1'b1; addr = 16'd5; wdata = 16'hDEAD;
        tick();
        req_v[0] = 1'b0;
        check("abort_wait_busy_pre", 32'(busy_v[0]), 32'h1);
        #2 rst = 1'b1;
        #1 check("abort_wait_outputs", 32'({ready_v[0], busy_v[0], error_v[0]}), 32'h0);
        tick();
        rst = 1'b0;

        // Abort a write while it sits in its DONE cycle
        req_v[0] = 1'b1; we = 1'b1; addr = 16'd5; wdata = 16'hBEEF;
        tick();
        req_v[0] = 1'b0;
        tick();
        tick();
        check("abort_done_ready_pre", 32'(ready_v[0]), 32'h1);
        rst = 1'b1;
        #1 check("abort_done_ready", 32'({ready_v[0], busy_v[0]}), 32'h0);
        tick();
        rst = 1'b0;
        access(0, 1'b0, 16'd5, 16'h0, 1'b0, rd, er, lat, bz);
        check("abort_addr5_kept", 32'(rd), 32'h1111);

        // WAIT=2 write then read
        access(0, 1'b1, 16'd3, 16'h1234, 1'b0, rd, er, lat, bz);
        check("w2_write_latency", 32'(lat), 32'd3);
        check("w2_write_busy", 32'(bz), 32'd3);
        check("w2_write_rdata", 32'({rd, er}), 32'h0);
        access(0, 1'b0, 16'd3, 16'h0, 1'b0, rd, er, lat, bz);
        check("w2_read_latency", 32'(lat), 32'd3);
        check("w2_read_data", 32'({rd, er}), 32'({16'h1234, 1'b0}));

        // WAIT=0 back-to-back reads of pre-loaded words
        for (int k = 0; k < 4; k++)
            access(1, 1'b1, 16'(k), 16'hA0 + 16'(k), 1'b0, rd, er, lat, bz);
        req_v[1] = 1'b1; we = 1'b0; addr = 16'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("w0_b2b_%0d", k), 32'({ready_v[1], rdata_v[1]}),
                  32'({1'b1, 16'hA0 + 16'(k)}));
            addr = 16'(k + 1);
        end
        req_v[1] = 1'b0;
        tick();
        check("w0_b2b_idle", 32'(busy_v[1]), 32'h0);

        // WAIT=0 read directly behind a write to the same word
        req_v[1] = 1'b1; we = 1'b1; addr = 16'd7; wdata = 16'h5555;
        tick();
        we = 1'b0; wdata = 16'h0;
        tick();
        check("w0_raw_same_addr", 32'({ready_v[1], rdata_v[1]}), 32'({1'b1, 16'h5555}));
        req_v[1] = 1'b0;
        tick();

        // Out-of-range accesses
        access(0, 1'b0, 16'h0400, 16'h0, 1'b0, rd, er, lat, bz);
        check("oor_read", 32'({lat[3:0], er, rd}), 32'({4'd3, 1'b1, 16'hC000}));
        access(0, 1'b1, 16'h03FF, 16'h7777, 1'b0, rd, er, lat, bz);
        access(0, 1'b1, 16'hFFFF, 16'h9999, 1'b0, rd, er, lat, bz);
        check("oor_write_error", 32'(er), 32'h1);
        access(0, 1'b0, 16'h03FF, 16'h0, 1'b0, rd, er, lat, bz);
        check("oor_last_word_kept", 32'({er, rd}), 32'({1'b0, 16'h7777}));

        // Input churn while busy on WAIT=5
        access(3, 1'b1, 16'd9, 16'h4242, 1'b1, rd, er, lat, bz);
        access(3, 1'b0, 16'd9, 16'h0, 1'b1, rd, er, lat, bz);
        check("churn_read", 32'({er, rd}), 32'({1'b0, 16'h4242}));

        // Latency and busy-width sweep
        for (int i = 1; i < NI; i++) begin
            access(i, 1'b0, 16'd1, 16'h0, 1'b0, rd, er, lat, bz);
            check($sformatf("sweep_w%0d_latency", WAITS[i]), 32'(lat), 32'(WAITS[i] + 1));
            check($sformatf("sweep_w%0d_busy", WAITS[i]), 32'(bz), 32'(WAITS[i] + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wait_model.md
Name: mem_wait_model

Overview:
- Parametrised, synthesisable memory slave for the stack CPU's memory port: single-port RAM with a programmable wait-state count and a request/ready handshake.
- Successor to the fixed-latency memory test model; adds configurable data/address width, depth, latency, back-to-back requests and an out-of-range error response.
- Sits between the CPU's memory interface (addr, write strobe, write data) and its read-data/ready inputs, in both simulation and FPGA builds.

Parameters:
- DATA_W, 16, data word width in bits
- ADDR_W, 16, CPU address width
- DEPTH, 1024, implemented words; addresses >= DEPTH are out of range
- WAIT, 2, wait states between request acceptance and ready (0..15)
- INIT_WORD, 16'hC000, value that every out-of-range read returns in rdata

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req  in  1  access request, sampled when the block is idle
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  ADDR_W  word address; sampled with req
- wdata  in  DATA_W  write data; sampled with req
- rdata  out  DATA_W  read data; valid only while ready = 1
- ready  out  1  one-cycle completion pulse
- busy  out  1  high from acceptance through the ready cycle
- error  out  1  with ready: the access was out of range

Behaviour:
- Reset: one clock, asynchronous and active-high. While rst = 1:
  - outputs: rdata = 0, ready = 0, busy = 0, error = 0
  - FSM goes to IDLE and the wait counter clears to 0
  - RAM contents are not cleared
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - if req = 1, latch we, addr and wdata, set busy = 1, and load cnt = WAIT
  - go to WAIT if WAIT > 0, otherwise go to DONE
- WAIT:
  - decrement cnt each cycle
  - when cnt reaches 1, go to DONE
  - req is ignored in this state
- DONE (exactly one cycle):
  - ready = 1
  - read: rdata = mem[addr_latched]
  - write: mem[addr_latched] <= wdata_latched on this clock edge; rdata = 0
  - out of range: error = 1, no write, rdata = INIT_WORD
  - next state: if req = 1 in DONE, accept the new request (back-to-back) and go to WAIT or DONE as from IDLE; otherwise go to IDLE with busy = 0
- Latency: request accepted at edge N → ready high during cycle N+WAIT+1. With WAIT = 0, ready follows in the next cycle.
- Throughput: one access per WAIT+1 cycles under continuous req.
- Range check: combinational compare addr_latched >= DEPTH. Only the low clog2(DEPTH) bits index the RAM.
- Input stability: inputs that change while busy = 1 have no effect, because values are latched at acceptance.
- Reset mid-access: the access is abandoned and no write occurs, even if reset asserts in the DONE cycle before the clock edge. ready never pulses for an aborted access.
- Read-after-write to the same address in consecutive requests returns the new data.
- The RAM array infers block RAM: synchronous write and registered read, with the read issued on the WAIT→DONE transition.

Decomposition:
- Shared package mem_pkg:
  - FSM state encoding (IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2)
  - default widths and the INIT_WORD default, shared with the CPU
- One natural sub-module: mem_array (DATA_W × DEPTH, single port, write-enable, registered read). It keeps RAM inference isolated from the control FSM.

Test Plan:
- Reset: assert rst asynchronously mid-WAIT of a write to addr 5 → ready, busy and error drop immediately; a later read of addr 5 returns its previous value.
- WAIT=2 write then read: write 16'h1234 to addr 3 (req at edge 0) → ready at cycle 3. Read addr 3 → rdata = 16'h1234 with ready.
- WAIT=0 back-to-back: req held high with reads of addrs 0..3 pre-loaded 16'hA0..A3 → ready every cycle, rdata A0, A1, A2, A3 in order.
- Out of range, DEPTH = 1024: read addr 16'h0400 → ready = 1, error = 1, rdata = 16'hC000. A write to 16'hFFFF leaves addr 16'h03FF unchanged.
- Input churn: change addr and wdata every cycle while busy → the access uses the values sampled at acceptance.
- Latency sweep WAIT ∈ {0, 1, 5, 15} → ready exactly WAIT+1 cycles after acceptance; busy is high for exactly WAIT+1 cycles.
